// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce.
//
// Drives one column low at a time, samples the active-low rows through a
// 2-FF synchronizer, debounces press and release, and reports the accepted
// key as a 4-bit code with a single-cycle strobe.
//
// Parameters:
//   SCAN_DIV      clock cycles each column is driven (2..65535)
//   DEBOUNCE_CNT  consecutive stable cycles to accept press/release (1..65535)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   row_n     in   [3:0] keypad rows, active-low, asynchronous
//   col_n     out  [3:0] column drive, one-hot low
//   key_out   out  [3:0] code of the last accepted key
//   pressed   out  one-cycle pulse on key accept
//   key_held  out  high from accept until release is accepted
//
// Build option:
//   KEYPAD_DIGIT_FILTER_EN  when defined, codes A..F are never accepted.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | drive col_idx, count dwell, sample rows on last dwell cycle
// DEBOUNCE | column frozen, latched row must stay low DEBOUNCE_CNT cycles
// HELD     | key accepted, wait for DEBOUNCE_CNT consecutive high cycles
// RELEASE  | one cycle: drop key_held, advance column, restart dwell

module keypad_scan #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [15:0] DEBOUNCE_CNT = 16'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_out,
  output logic       pressed,
  output logic       key_held
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_LAST = SCAN_DIV - 16'd1;
  localparam logic [15:0] STAB_LAST  = DEBOUNCE_CNT - 16'd1;

  logic [3:0]  row_meta;
  logic [3:0]  row_s;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  col_idx;
  logic [1:0]  col_idx_nxt;
  logic [15:0] dwell_cnt;
  logic [15:0] dwell_cnt_nxt;
  logic [15:0] stab_cnt;
  logic [15:0] stab_cnt_nxt;
  logic [1:0]  row_idx;
  logic [1:0]  row_idx_nxt;
  logic [3:0]  key_out_nxt;
  logic        pressed_nxt;
  logic        key_held_nxt;

  logic        row_low;
  logic        accept_ok;
  logic [3:0]  key_code;

  // lowest-numbered low row wins when several rows are low
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] map_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // row_n is asynchronous to clk; idle (released) value is all-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_s    <= row_meta;
    end
  end

  assign col_n    = ~(4'b0001 << col_idx);
  assign row_low  = ~row_s[row_idx];
  assign key_code = map_code(row_idx, col_idx);

`ifdef KEYPAD_DIGIT_FILTER_EN
  // letter keys still run through HELD so their release is debounced,
  // they just never surface as an accepted key
  assign accept_ok = (key_code <= 4'h9);
`else
  assign accept_ok = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    dwell_cnt_nxt = dwell_cnt;
    stab_cnt_nxt  = stab_cnt;
    row_idx_nxt   = row_idx;
    key_out_nxt   = key_out;
    pressed_nxt   = 1'b0;
    key_held_nxt  = key_held;

    case (state)
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          if (row_s != 4'hF) begin
            row_idx_nxt   = low_row(row_s);
            stab_cnt_nxt  = 16'd0;
            dwell_cnt_nxt = 16'd0;
            state_nxt     = ST_DEBOUNCE;
          end else begin
            col_idx_nxt   = col_idx + 2'd1;
            dwell_cnt_nxt = 16'd0;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + 16'd1;
        end
      end

      ST_DEBOUNCE: begin
        if (!row_low) begin
          col_idx_nxt   = col_idx + 2'd1;
          dwell_cnt_nxt = 16'd0;
          stab_cnt_nxt  = 16'd0;
          state_nxt     = ST_SCAN;
        end else if (stab_cnt == STAB_LAST) begin
          stab_cnt_nxt = 16'd0;
          state_nxt    = ST_HELD;
          if (accept_ok) begin
            key_out_nxt  = key_code;
            pressed_nxt  = 1'b1;
            key_held_nxt = 1'b1;
          end
        end else begin
          stab_cnt_nxt = stab_cnt + 16'd1;
        end
      end

      ST_HELD: begin
        // only the latched row matters; other keys are ignored (no rollover)
        if (row_low) begin
          stab_cnt_nxt = 16'd0;
        end else if (stab_cnt == STAB_LAST) begin
          stab_cnt_nxt = 16'd0;
          state_nxt    = ST_RELEASE;
        end else begin
          stab_cnt_nxt = stab_cnt + 16'd1;
        end
      end

      ST_RELEASE: begin
        key_held_nxt  = 1'b0;
        col_idx_nxt   = col_idx + 2'd1;
        dwell_cnt_nxt = 16'd0;
        stab_cnt_nxt  = 16'd0;
        state_nxt     = ST_SCAN;
      end

      default: begin
        state_nxt     = ST_SCAN;
        col_idx_nxt   = 2'd0;
        dwell_cnt_nxt = 16'd0;
        stab_cnt_nxt  = 16'd0;
        key_held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      dwell_cnt <= 16'd0;
      stab_cnt  <= 16'd0;
      row_idx   <= 2'd0;
      key_out   <= 4'h0;
      pressed   <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      stab_cnt  <= stab_cnt_nxt;
      row_idx   <= row_idx_nxt;
      key_out   <= key_out_nxt;
      pressed   <= pressed_nxt;
      key_held  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan with SCAN_DIV=4,
// DEBOUNCE_CNT=8. A keypad model turns the pressed-key matrix and the
// column drive into row levels; expected key codes are queued by the
// stimulus and popped by a monitor on every pressed pulse.

module tb_keypad_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_out;
  logic       pressed;
  logic       key_held;

  logic [15:0] keys;      // bit r*4+c set means key (row r, col c) is down
  logic [3:0]  exp_q[$];
  int          n_cmp;
  int          n_err;
  int          n_pulse;

  keypad_scan #(
    .SCAN_DIV     (16'd4),
    .DEBOUNCE_CNT (16'd8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_out  (key_out),
    .pressed  (pressed),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && pressed) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got key_out %0h required no pulse at %0t", key_out, $time);
      end else begin
        check("key_code", 32'(key_out), 32'(exp_q.pop_front()));
        check("held_with_pulse", 32'(key_held), 32'd1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic wait_col(input string name, input logic [3:0] target);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (col_n !== target && k < 40);
    if (col_n !== target) check(name, 32'(col_n), 32'(target));
  endtask

  task automatic wait_pulse(input string name, input int base);
    int k;
    k = 0;
    while (n_pulse == base && k < 100) begin
      tick();
      k++;
    end
    check(name, 32'(n_pulse - base), 32'd1);
  endtask

  task automatic wait_release(input string name);
    int k;
    k = 0;
    while (key_held !== 1'b0 && k < 60) begin
      tick();
      k++;
    end
    check(name, 32'(key_held), 32'd0);
  endtask

  initial begin
    int base;
    n_cmp   = 0;
    n_err   = 0;
    n_pulse = 0;
    keys    = 16'h0;
    rst_n   = 1'b0;
    repeat (3) tick();
    check("rst_col_n", 32'(col_n), 32'hE);
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);

    // idle scan: each column held 4 clocks, wraps back to column 0
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("scan_col_k%0d", k), 32'(col_n), 32'(col_of((k / 4) % 4)));
      check("scan_no_pulse", 32'(pressed), 32'd0);
      tick();
    end

    // r1/c2 held steady -> single '6', release resumes scanning at c3
    base = n_pulse;
    exp_q.push_back(4'h6);
    keys[1*4+2] = 1'b1;
    wait_pulse("pulse_6", base);
    repeat (20) tick();
    check("held_6", 32'(key_held), 32'd1);
    check("one_pulse_6", 32'(n_pulse - base), 32'd1);
    keys = 16'h0;
    wait_release("release_6");
    check("resume_col", 32'(col_n), 32'h7);

    // r0/c1 with a one-cycle bounce mid-debounce -> abort, then re-press '2'
    wait_col("wait_c2", 4'b1011);
    keys[0*4+1] = 1'b1;
    wait_col("wait_c1", 4'b1101);
    base = n_pulse;
    repeat (6) tick();
    keys[0*4+1] = 1'b0;
    tick();
    keys[0*4+1] = 1'b1;
    repeat (2) tick();
    check("bounce_col_advance", 32'(col_n), 32'hB);
    check("bounce_no_pulse", 32'(n_pulse - base), 32'd0);
    exp_q.push_back(4'h2);
    wait_pulse("pulse_2", base);
    keys = 16'h0;
    wait_release("release_2");

    // r0 and r2 together on c0 -> '1'; c3 press while held is ignored
    base = n_pulse;
    exp_q.push_back(4'h1);
    keys[0*4+0] = 1'b1;
    keys[2*4+0] = 1'b1;
    wait_pulse("pulse_1", base);
    repeat (3) tick();
    keys[0*4+3] = 1'b1;
    repeat (40) tick();
    check("no_rollover_pulse", 32'(n_pulse - base), 32'd1);
    check("no_rollover_key", 32'(key_out), 32'h1);
    check("no_rollover_held", 32'(key_held), 32'd1);
    keys = 16'h0;
    wait_release("release_1");

    // r3/c3 -> 'D'
    base = n_pulse;
    keys[3*4+3] = 1'b1;
`ifdef KEYPAD_DIGIT_FILTER_EN
    repeat (60) tick();
    check("filter_no_pulse", 32'(n_pulse - base), 32'd0);
    check("filter_key_kept", 32'(key_out), 32'h1);
    check("filter_not_held", 32'(key_held), 32'd0);
    keys = 16'h0;
    repeat (30) tick();
`else
    exp_q.push_back(4'hD);
    wait_pulse("pulse_D", base);
    check("key_D_after", 32'(key_out), 32'hD);
    keys = 16'h0;
    wait_release("release_D");
`endif

    // reset while debouncing r0/c2
    wait_col("wait_c1_rst", 4'b1101);
    keys[0*4+2] = 1'b1;
    wait_col("wait_c2_rst", 4'b1011);
    base = n_pulse;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_col_n", 32'(col_n), 32'hE);
    check("midrst_key_out", 32'(key_out), 32'h0);
    check("midrst_key_held", 32'(key_held), 32'd0);
    check("midrst_pressed", 32'(pressed), 32'd0);
    keys = 16'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("post_rst_col", 32'(col_n), 32'hE);
    repeat (60) tick();
    check("post_rst_no_pulse", 32'(n_pulse - base), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
